// File: rtl/boot_rom_pkg.sv
// Shared parameters and types for the boot ROM two-port arbiter.
package boot_rom_pkg;

    localparam int unsigned DEF_ROM_WORDS = 548;
    localparam int unsigned DEF_ROM_AW    = 10;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Port that owns an arbitration slot or an in-flight response.
    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Granted request as seen by the address checker.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
    } rom_req_t;

    // Response tracking captured on every grant.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } resp_t;

endpackage

// File: rtl/boot_rom_addr_chk.sv
// Combinational decode of the granted request: region hit, populated-word range, write attempt.
module boot_rom_addr_chk
    import boot_rom_pkg::*;
#(
    parameter int unsigned ROM_WORDS = DEF_ROM_WORDS,
    parameter int unsigned ROM_AW    = DEF_ROM_AW,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  rom_req_t          req,
    output logic [ROM_AW-1:0] word_c,
    output logic              err_c
);

    localparam int unsigned TAG_LSB = ROM_AW + 2;

    logic in_region;
    logic over_range;
    logic unused_byte_sel;

    // Word reads only; the byte offset carries no meaning for the ROM.
    assign unused_byte_sel = ^req.addr[1:0];

    // Region tag compare, word extraction and the three error sources.
    always_comb begin
        in_region  = (req.addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
        word_c     = req.addr[TAG_LSB-1:2];
        over_range = ({1'b0, word_c} >= (ROM_AW + 1)'(ROM_WORDS));
        err_c      = !in_region || over_range || req.we;
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Round-robin sharing of the single-ported boot ROM between instruction-fetch and data ports.
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int unsigned ROM_WORDS = DEF_ROM_WORDS,
    parameter int unsigned ROM_AW    = DEF_ROM_AW,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,

    input  logic              data_req_i,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,

    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i
);

    owner_e            last_owner;
    resp_t             resp_q;

    logic              gnt_instr;
    logic              gnt_data;
    logic              gnt_any;
    owner_e            gnt_owner;
    rom_req_t          gnt_req;
    logic [ROM_AW-1:0] chk_word;
    logic              chk_err;

    // Single decoder shared by both ports, fed with whichever request wins.
    boot_rom_addr_chk #(
        .ROM_WORDS (ROM_WORDS),
        .ROM_AW    (ROM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_chk (
        .req    (gnt_req),
        .word_c (chk_word),
        .err_c  (chk_err)
    );

    // Arbitration, request mux and ROM pin drive; nothing is granted while in reset.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        gnt_owner = OWN_INSTR;
        gnt_req   = '0;
        rom_csn_o = 1'b1;
        rom_a_o   = '0;

        if (!RST) begin
            if (instr_req_i && data_req_i) begin
                gnt_instr = (last_owner == OWN_DATA);
                gnt_data  = (last_owner == OWN_INSTR);
            end else begin
                gnt_instr = instr_req_i;
                gnt_data  = data_req_i;
            end
        end

        gnt_any = gnt_instr || gnt_data;

        if (gnt_data) begin
            gnt_owner    = OWN_DATA;
            gnt_req.addr = data_addr_i;
            gnt_req.we   = data_we_i;
        end else if (gnt_instr) begin
            gnt_owner    = OWN_INSTR;
            gnt_req.addr = instr_addr_i;
            gnt_req.we   = 1'b0;
        end

        // Error grants still answer next cycle but never touch the ROM.
        if (gnt_any && !chk_err) begin
            rom_csn_o = 1'b0;
            rom_a_o   = chk_word;
        end
    end

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    // Round-robin pointer and one-deep response tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_owner <= OWN_DATA;
            resp_q     <= '{valid: 1'b0, owner: OWN_INSTR, err: 1'b0};
        end else begin
            if (gnt_any) begin
                last_owner <= gnt_owner;
            end
            resp_q.valid <= gnt_any;
            resp_q.owner <= gnt_owner;
            resp_q.err   <= gnt_any && chk_err;
        end
    end

    // Response demux; reset squashes any response still in flight.
    always_comb begin
        instr_rvalid_o = !RST && resp_q.valid && (resp_q.owner == OWN_INSTR);
        data_rvalid_o  = !RST && resp_q.valid && (resp_q.owner == OWN_DATA);
        instr_err_o    = instr_rvalid_o && resp_q.err;
        data_err_o     = data_rvalid_o && resp_q.err;
        instr_rdata_o  = (instr_rvalid_o && !resp_q.err) ? rom_q_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !resp_q.err) ? rom_q_i : 32'h0;
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed and constrained-random checks of boot_rom_arbiter against a behavioural ROM.
module tb_boot_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        rom_csn;
    logic [9:0]  rom_a;
    logic [31:0] rom_q = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    boot_rom_arbiter dut (
        .CLK            (clk),
        .RST            (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .rom_csn_o      (rom_csn),
        .rom_a_o        (rom_a),
        .rom_q_i        (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [9:0] a);
        return 32'hC0DE_0000 ^ ({22'h0, a} * 32'h0001_0011);
    endfunction

    // Behavioural ROM macro: registered address, data valid the cycle after CSN low.
    always @(posedge clk) begin
        if (!rom_csn) rom_q <= rom_fn(rom_a);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic gi, input logic gd,
                           input logic csn, input logic [9:0] a);
        chk({tag, ".instr_gnt"}, 32'(instr_gnt), 32'(gi));
        chk({tag, ".data_gnt"},  32'(data_gnt),  32'(gd));
        chk({tag, ".rom_csn"},   32'(rom_csn),   32'(csn));
        chk({tag, ".rom_a"},     32'(rom_a),     32'(a));
    endtask

    task automatic chk_rsp(input string tag,
                           input logic iv, input logic [31:0] id, input logic ie,
                           input logic dv, input logic [31:0] dd, input logic de);
        chk({tag, ".instr_rvalid"}, 32'(instr_rvalid), 32'(iv));
        chk({tag, ".instr_rdata"},  instr_rdata,       id);
        chk({tag, ".instr_err"},    32'(instr_err),    32'(ie));
        chk({tag, ".data_rvalid"},  32'(data_rvalid),  32'(dv));
        chk({tag, ".data_rdata"},   data_rdata,        dd);
        chk({tag, ".data_err"},     32'(data_err),     32'(de));
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checking.
    task automatic drive(input logic r, input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic [31:0] daddr, input logic dwe);
        @(negedge clk);
        rst        = r;
        instr_req  = ireq;
        instr_addr = iaddr;
        data_req   = dreq;
        data_addr  = daddr;
        data_we    = dwe;
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [9:0] w;
        w = 10'($urandom_range(0, 600));
        if ($urandom_range(0, 15) == 0) return 32'h0000_1000 + {20'h0, w, 2'b00};
        return {20'h0, w, 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pi, pd, wd, exp_last;
        logic [31:0] ai, ad, eaddr;
        logic        egi, egd, eerr, ecsn;
        logic [9:0]  ew;
        logic        pv, po, pe;
        logic [9:0]  pw;

        rst = 1'b1; instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_addr = '0; data_we = 1'b0;

        // Reset holds everything quiet even with requests pending
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0);
        chk_req("rst", 1'b0, 1'b0, 1'b1, 10'd0);
        chk_rsp("rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Single fetch of word 0
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_req("i0_req", 1'b1, 1'b0, 1'b0, 10'd0);
        chk_rsp("i0_req", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_req("i0_rsp", 1'b0, 1'b0, 1'b1, 10'd0);
        chk_rsp("i0_rsp", 1'b1, rom_fn(10'd0), 1'b0, 1'b0, 32'h0, 1'b0);

        // Contention: instr won last, so data goes first, then strict alternation
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        chk_req("cont1", 1'b0, 1'b1, 1'b0, 10'd8);
        chk_rsp("cont1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        chk_req("cont2", 1'b1, 1'b0, 1'b0, 10'd4);
        chk_rsp("cont2", 1'b0, 32'h0, 1'b0, 1'b1, rom_fn(10'd8), 1'b0);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        chk_req("cont3", 1'b0, 1'b1, 1'b0, 10'd8);
        chk_rsp("cont3", 1'b1, rom_fn(10'd4), 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        chk_req("cont4", 1'b1, 1'b0, 1'b0, 10'd4);
        chk_rsp("cont4", 1'b0, 32'h0, 1'b0, 1'b1, rom_fn(10'd8), 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_req("cont5", 1'b0, 1'b0, 1'b1, 10'd0);
        chk_rsp("cont5", 1'b1, rom_fn(10'd4), 1'b0, 1'b0, 32'h0, 1'b0);

        // Data write is an error with no ROM access
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        chk_req("dwe_req", 1'b0, 1'b1, 1'b1, 10'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_rsp("dwe_rsp", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);

        // Range boundary: word 548 and out-of-region fail, word 547 reads
        drive(1'b0, 1'b1, 32'h890, 1'b0, 32'h0, 1'b0);
        chk_req("w548_req", 1'b1, 1'b0, 1'b1, 10'd0);
        drive(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
        chk_req("oor_req", 1'b1, 1'b0, 1'b1, 10'd0);
        chk_rsp("w548_rsp", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h88C, 1'b0, 32'h0, 1'b0);
        chk_req("w547_req", 1'b1, 1'b0, 1'b0, 10'd547);
        chk_rsp("oor_rsp", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_rsp("w547_rsp", 1'b1, rom_fn(10'd547), 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset right after a grant discards its response
        drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        chk_req("pre_rst", 1'b1, 1'b0, 1'b0, 10'd1);
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'hC, 1'b0);
        chk_req("mid_rst", 1'b0, 1'b0, 1'b1, 10'd0);
        chk_rsp("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'hC, 1'b0);
        chk_req("post_rst1", 1'b1, 1'b0, 1'b0, 10'd0);
        chk_rsp("post_rst1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'hC, 1'b0);
        chk_req("post_rst2", 1'b0, 1'b1, 1'b0, 10'd3);
        chk_rsp("post_rst2", 1'b1, rom_fn(10'd0), 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_rsp("post_rst3", 1'b0, 32'h0, 1'b0, 1'b1, rom_fn(10'd3), 1'b0);

        // Random OBI traffic: requests held until granted, checked against a reference
        pi = 1'b0; pd = 1'b0; wd = 1'b0; ai = '0; ad = '0;
        exp_last = 1'b1;
        pv = 1'b0; po = 1'b0; pe = 1'b0; pw = '0;
        for (int c = 0; c < 300; c++) begin
            if (!pi && ($urandom_range(0, 1) == 1)) begin
                pi = 1'b1; ai = rnd_addr();
            end
            if (!pd && ($urandom_range(0, 1) == 1)) begin
                pd = 1'b1; ad = rnd_addr(); wd = ($urandom_range(0, 7) == 0);
            end
            drive(1'b0, pi, ai, pd, ad, pd && wd);

            chk_rsp("rnd_rsp",
                    pv && !po, (pv && !po && !pe) ? rom_fn(pw) : 32'h0, pv && !po && pe,
                    pv && po,  (pv && po && !pe)  ? rom_fn(pw) : 32'h0, pv && po && pe);

            egi   = pi && (!pd || exp_last);
            egd   = pd && !egi;
            eaddr = egi ? ai : ad;
            ew    = eaddr[11:2];
            eerr  = (eaddr[31:12] != 20'h0) || (32'(ew) >= 32'd548) || (egd && wd);
            ecsn  = !((egi || egd) && !eerr);
            chk_req("rnd_req", egi, egd, ecsn, ecsn ? 10'd0 : ew);

            pv = egi || egd; po = egd; pe = eerr; pw = ew;
            if (egi) begin pi = 1'b0; exp_last = 1'b0; end
            if (egd) begin pd = 1'b0; exp_last = 1'b1; end
        end

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rnd_last",
                pv && !po, (pv && !po && !pe) ? rom_fn(pw) : 32'h0, pv && !po && pe,
                pv && po,  (pv && po && !pe)  ? rom_fn(pw) : 32'h0, pv && po && pe);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_rom_arbiter.md
# boot_rom_arbiter

Two-port arbiter that shares the single-ported boot ROM macro (1024-entry address space, 548 populated 32-bit words, 1-cycle registered-address read) between the core's instruction-fetch port and data port. Sits between the core's two request/grant/rvalid (OBI-style) master interfaces and the ROM's CSN/A/Q pins. Provides round-robin arbitration, address decoding, range and write-error checking, and pipelined back-to-back reads at one access per cycle.

## Interface
- ROM_WORDS, 548, number of populated ROM words; word index >= ROM_WORDS is an error
- ROM_AW, 10, ROM word-address width
- BASE_ADDR, 32'h0000_0000, byte base of the ROM region; region size 2^(ROM_AW+2) bytes

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error, qualified by rvalid
- data_req_i  in  1  data request
- data_addr_i  in  32  data byte address
- data_we_i  in  1  data write enable
- data_gnt_o  out  1  data grant (combinational)
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error, qualified by rvalid
- rom_csn_o  out  1  ROM chip select, active-low
- rom_a_o  out  ROM_AW  ROM word address
- rom_q_i  in  32  ROM read data

## Operation
- Arbitration: at most one grant per cycle. Single requester: granted. Both: grant the port not granted last; `last_owner` reset value = data, so instruction wins first contention.
- `last_owner` updates only on a grant cycle.
- Decode of granted request: in_region = addr[31:ROM_AW+2] == BASE_ADDR[31:ROM_AW+2]; word = addr[ROM_AW+1:2]; addr[1:0] ignored (word read).
- Error when: !in_region, word >= ROM_WORDS, or data_we_i=1 on data port. Error grants: rom_csn_o=1 (no ROM access), response rdata=0, err=1.
- Valid read grants: rom_csn_o=0, rom_a_o=word.
- rom_csn_o=1 on every non-access cycle; rom_a_o=0 when csn high.
- Response tracking: registers resp_valid, resp_owner, resp_err captured on each grant; no requester backpressure on rvalid.
- rdata mux: owner's rdata = rom_q_i if !resp_err else 0; non-owner rdata = 0.
- Requests not granted must be held by master (OBI); arbiter does not store them.

## Timing
- Grant combinational in request cycle; rvalid + rdata exactly 1 cycle after grant, every case including errors.
- Back-to-back: grants every cycle sustain 1 response/cycle, alternating under contention (I, D, I, D...).
- Reset (RST=1 at edge): resp_valid=0, last_owner=data. During RST: all gnt_o=0, rom_csn_o=1, rom_a_o=0, rvalid_o=0, rdata_o=0, err_o=0.
- Reset mid-transaction: a grant issued in the cycle before reset asserts produces no rvalid; response is discarded.
- Reset release: first grant possible in cycle after RST deasserts.
- Simultaneous response and new grant: allowed; response of grant N and grant N+1 overlap in one cycle without stall.

## Structure
- Shared package boot_rom_pkg: ROM_WORDS, ROM_AW, BASE_ADDR defaults, owner enum {OWN_INSTR, OWN_DATA}.
- One natural sub-module: boot_rom_addr_chk (combinational in_region / range / write error decode), instantiated once on the muxed granted request.
- Top contains arbiter, response registers, rdata demux; ~200 lines.

## Test plan
- Reset then single instr_req addr 0x0 -> gnt same cycle, rom_csn_o=0, rom_a_o=0; next cycle instr_rvalid_o=1, rdata=ROM word 0, err=0.
- Both req held 4 cycles, addrs 0x10/0x20 -> grants I,D,I,D; rom_a_o 4,8,4,8; rvalid alternates, 1-cycle lag, no bubbles.
- data_req with data_we_i=1 addr 0x8 -> gnt, rom_csn_o=1; next cycle data_rvalid_o=1, data_err_o=1, rdata=0.
- instr addr 0x890 (word 548) and 0x1000 (out of region) -> both err=1, rdata=0, rom_csn_o=1; addr 0x88C (word 547) -> valid read, err=0.
- Grant in cycle k, RST=1 in cycle k+1 -> no rvalid in k+1; after release, contention grants instr first.
- Random OBI traffic vs reference model of ROM contents -> every rvalid matches model, no starvation beyond 1 cycle under contention.
